// File: rtl/tw_ram_loader_ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_pkg
// Purpose  : Shared definitions for the run-time twiddle loader: loader state
//            encoding, bit-reversal helper and the identity-twiddle default
//            returned while no table is loaded.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  localparam int TW_DEFAULT   = 1;
  localparam int BITREV_MAX_W = 10;

  // Reverses the low 'width' bits of value; bits at and above 'width' are 0.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] value,
    input int                      width
  );
    logic [BITREV_MAX_W-1:0] r_res;
    r_res = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < width) begin
        r_res[i] = value[width-1-i];
      end
    end
    return r_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tw_ram_loader_ntt_if.sv
`default_nettype none
// ============================================================================
// Module   : tw_ram_loader_ntt_if
// Purpose  : Bundles the load stream, status flags and butterfly read port of
//            the twiddle loader.
// Ports    : start, ld_valid/ld_ready/ld_data/ld_last (load stream),
//            busy/loaded/err (status), raddr/b (read port).
//            master = host/DMA + butterfly side, slave = loader.
// Revision : 1.0 - initial release
// ============================================================================
interface tw_ram_loader_ntt_if #(
  parameter int LOGN = 3,
  parameter int LOGQ = 64
);
  logic            start;
  logic            ld_valid;
  logic            ld_ready;
  logic [LOGQ-1:0] ld_data;
  logic            ld_last;
  logic            busy;
  logic            loaded;
  logic            err;
  logic [LOGN-1:0] raddr;
  logic [LOGQ-1:0] b;

  modport master (
    output start, ld_valid, ld_data, ld_last, raddr,
    input  ld_ready, busy, loaded, err, b
  );

  modport slave (
    input  start, ld_valid, ld_data, ld_last, raddr,
    output ld_ready, busy, loaded, err, b
  );
endinterface
`default_nettype wire

// File: rtl/tw_ram_loader_ntt_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : tw_sdp_ram
// Purpose  : Simple dual-port distributed RAM, one write port and one
//            registered read port. Contents are never reset.
// Ports    : clk, we/waddr/wdata (write), raddr/rdata (registered read)
// Revision : 1.0 - initial release
// ============================================================================
module tw_sdp_ram #(
  parameter int AW = 3,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/tw_ram_loader_ntt.sv
`default_nettype none
// ============================================================================
// Module   : tw_ram_loader_ntt
// Purpose  : Run-time writable twiddle table for one NTT/INTT stage. Accepts
//            2^LOGN words on a valid/ready stream, stores word k at
//            bitrev(k) (or k when BITREV=0) and serves them with the same
//            one-cycle read latency as the fixed twiddle ROMs. While no valid
//            table is present the read port returns 1 (identity twiddle).
// Ports    : clk, rst_n (sync, active-low), bus (tw_ram_loader_ntt_if.slave)
// Revision : 1.0 - initial release
// ============================================================================
module tw_ram_loader_ntt
  import ntt_pkg::*;
#(
  parameter int LOGN   = 3,
  parameter int LOGQ   = 64,
  parameter int BITREV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tw_ram_loader_ntt_if.slave    bus
);
  localparam int            c_depth    = 1 << LOGN;
  localparam logic [LOGN:0] c_last_cnt = (LOGN+1)'(c_depth - 1);

  ld_state_t       r_state;
  ld_state_t       w_state_nxt;
  logic [LOGN:0]   r_wcnt;
  logic [LOGN:0]   w_wcnt_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            r_rd_valid;
  logic            w_accept;
  logic            w_we;
  logic [LOGN:0]   w_cnt_eff;
  logic [LOGN-1:0] w_waddr;
  logic [LOGQ-1:0] w_rdata;
  logic            w_loaded;

  // A start coinciding with an accepted beat makes that beat the first one
  // of the new load, so the address is computed from the restarted count.
  assign w_cnt_eff = bus.start ? '0 : r_wcnt;
  assign w_accept  = bus.ld_valid && (r_state == ST_LOAD);

  generate
    if (BITREV != 0) begin : g_addr_bitrev
      assign w_waddr = LOGN'(bitrev(BITREV_MAX_W'(w_cnt_eff[LOGN-1:0]), LOGN));
    end else begin : g_addr_linear
      assign w_waddr = w_cnt_eff[LOGN-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_err      <= w_err_nxt;
      r_rd_valid <= w_loaded;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_err_nxt   = r_err;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_LOAD;
          w_wcnt_nxt  = '0;
          w_err_nxt   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.start) begin
          w_wcnt_nxt = '0;
          w_err_nxt  = 1'b0;
        end
        if (w_accept) begin
          w_we       = 1'b1;
          w_wcnt_nxt = w_cnt_eff + 1'b1;
          if (w_cnt_eff == c_last_cnt) begin
            // Table is complete; a missing ld_last is flagged but the table
            // is still published.
            w_state_nxt = ST_DONE;
            if (!bus.ld_last) begin
              w_err_nxt = 1'b1;
            end
          end else if (bus.ld_last) begin
            // Short load: abandon without exposing the partial table.
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_loaded     = (r_state == ST_DONE);
  assign bus.ld_ready = (r_state == ST_LOAD);
  assign bus.busy     = (r_state == ST_LOAD);
  assign bus.loaded   = w_loaded;
  assign bus.err      = r_err;

  tw_sdp_ram #(
    .AW (LOGN),
    .DW (LOGQ)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (bus.ld_data),
    .raddr (bus.raddr),
    .rdata (w_rdata)
  );

  // r_rd_valid is loaded delayed to line up with the registered RAM output.
  assign bus.b = r_rd_valid ? w_rdata : LOGQ'(TW_DEFAULT);
endmodule
`default_nettype wire

// File: tb/tb_tw_ram_loader_ntt.sv
`default_nettype none
// ============================================================================
// Module   : tb_tw_ram_loader_ntt
// Purpose  : Self-checking bench for tw_ram_loader_ntt. Two instances (BITREV=1
//            and BITREV=0) receive identical stimulus; a table-level model
//            predicts the status flags and read data of both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tw_ram_loader_ntt;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ld_valid, ld_last;
  logic [63:0] ld_data;
  logic [2:0]  raddr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: expected table contents per instance and status flags.
  logic [63:0] m_mem [2][N];
  int          mk;
  logic        exp_busy, exp_loaded, exp_err;

  always #5 clk = ~clk;

  tw_ram_loader_ntt_if #(.LOGN(3), .LOGQ(64)) bus0 ();
  tw_ram_loader_ntt_if #(.LOGN(3), .LOGQ(64)) bus1 ();

  assign bus0.start = start;    assign bus1.start = start;
  assign bus0.ld_valid = ld_valid; assign bus1.ld_valid = ld_valid;
  assign bus0.ld_data = ld_data;  assign bus1.ld_data = ld_data;
  assign bus0.ld_last = ld_last;  assign bus1.ld_last = ld_last;
  assign bus0.raddr = raddr;    assign bus1.raddr = raddr;

  tw_ram_loader_ntt #(.LOGN(3), .LOGQ(64), .BITREV(1)) dut_rev (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave));
  tw_ram_loader_ntt #(.LOGN(3), .LOGQ(64), .BITREV(0)) dut_lin (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave));

  function automatic int rev3(int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(string tag);
    chk({tag, ".rev.ready"},  64'(bus0.ld_ready), 64'(exp_busy));
    chk({tag, ".rev.busy"},   64'(bus0.busy),     64'(exp_busy));
    chk({tag, ".rev.loaded"}, 64'(bus0.loaded),   64'(exp_loaded));
    chk({tag, ".rev.err"},    64'(bus0.err),      64'(exp_err));
    chk({tag, ".lin.busy"},   64'(bus1.busy),     64'(exp_busy));
    chk({tag, ".lin.loaded"}, 64'(bus1.loaded),   64'(exp_loaded));
    chk({tag, ".lin.err"},    64'(bus1.err),      64'(exp_err));
  endtask

  task automatic chk_table(string tag);
    for (int a = 0; a < N; a++) begin
      raddr = 3'(a);
      tick();
      chk($sformatf("%s.rev.b[%0d]", tag, a), bus0.b, exp_loaded ? m_mem[0][a] : 64'd1);
      chk($sformatf("%s.lin.b[%0d]", tag, a), bus1.b, exp_loaded ? m_mem[1][a] : 64'd1);
    end
  endtask

  task automatic do_start();
    start = 1'b1; ld_valid = 1'b0;
    tick();
    start = 1'b0;
    mk = 0; exp_busy = 1'b1; exp_loaded = 1'b0; exp_err = 1'b0;
  endtask

  // One accepted beat; optionally with a simultaneous start (restart).
  task automatic beat(logic [63:0] d, logic last, logic with_start);
    ld_valid = 1'b1; ld_data = d; ld_last = last; start = with_start;
    if (with_start) begin
      mk = 0; exp_err = 1'b0;
    end
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
    m_mem[0][rev3(mk)] = d;
    m_mem[1][mk]       = d;
    if (mk == N-1) begin
      exp_busy = 1'b0; exp_loaded = 1'b1;
      if (!last) exp_err = 1'b1;
    end else if (last) begin
      exp_busy = 1'b0; exp_err = 1'b1;
    end
    mk++;
  endtask

  // mode 0: base+k data, mode 1: random data. gaps: random idle cycles.
  task automatic full_load(logic [63:0] base, int mode, logic gaps, logic with_last);
    for (int k = 0; k < N; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      beat(mode == 0 ? base + 64'(k) : {$urandom, $urandom}, with_last && (k == N-1), 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; raddr = '0;
    exp_busy = 1'b0; exp_loaded = 1'b0; exp_err = 1'b0; mk = 0;
    for (int i = 0; i < N; i++) begin
      m_mem[0][i] = '0; m_mem[1][i] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;

    // 1: reset state, identity reads
    chk_status("reset");
    chk("reset.rev.b", bus0.b, 64'd1);
    chk_table("unloaded");

    // 2: back-to-back load 0x10..0x17
    do_start();
    chk_status("load2.busy");
    full_load(64'h10, 0, 1'b0, 1'b1);
    chk_status("load2.done");
    raddr = 3'd4; tick(); chk("load2.rev.b4", bus0.b, 64'h11);
    raddr = 3'd6; tick(); chk("load2.rev.b6", bus0.b, 64'h13);
    raddr = 3'd7; tick(); chk("load2.rev.b7", bus0.b, 64'h17);
    raddr = 3'd5; tick(); chk("load2.lin.b5", bus1.b, 64'h15);
    chk_table("load2");

    // 3: gapped stream, then random data with gaps
    do_start();
    full_load(64'h10, 0, 1'b1, 1'b1);
    chk_status("load3");
    chk_table("load3");
    do_start();
    full_load(64'h0, 1, 1'b1, 1'b1);
    chk_status("load3r");
    chk_table("load3r");

    // 4: early ld_last on beat 3
    do_start();
    for (int k = 0; k < 4; k++) beat({$urandom, $urandom}, k == 3, 1'b0);
    chk_status("short");
    chk_table("short");
    do_start();
    full_load(64'h0, 1, 1'b0, 1'b1);
    chk_status("after_short");
    chk_table("after_short");

    // restart in LOAD with a beat in the same cycle
    do_start();
    for (int k = 0; k < 3; k++) beat({$urandom, $urandom}, 1'b0, 1'b0);
    beat({$urandom, $urandom}, 1'b0, 1'b1);
    chk_status("restart.mid");
    for (int k = 1; k < N; k++) beat({$urandom, $urandom}, k == N-1, 1'b0);
    chk_status("restart.done");
    chk_table("restart");

    // 5: full load without ld_last, then start while DONE
    do_start();
    full_load(64'h0, 1, 1'b1, 1'b0);
    chk_status("nolast");
    chk_table("nolast");
    do_start();
    chk_status("reload");
    raddr = 3'd2; tick();
    chk("reload.rev.b", bus0.b, 64'd1);
    chk("reload.lin.b", bus1.b, 64'd1);

    // 6: reset after 5 beats, then clean load 0xA0..0xA7
    for (int k = 0; k < 5; k++) beat({$urandom, $urandom}, 1'b0, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_busy = 1'b0; exp_loaded = 1'b0; exp_err = 1'b0;
    chk_status("midreset");
    chk_table("midreset");
    do_start();
    full_load(64'hA0, 0, 1'b0, 1'b1);
    chk_status("loadA");
    raddr = 3'd1; tick(); chk("loadA.rev.b1", bus0.b, 64'hA4);
    chk_table("loadA");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tw_ram_loader_ntt.md
Name: tw_ram_loader_ntt

Overview:
Run-time writable twiddle memory for one NTT/INTT stage. It is the write-side counterpart of the fixed per-stage twiddle ROMs.
- Accepts a valid/ready stream of 2^LOGN twiddle words from the host or DMA.
- Stores each word at its bit-reversed address.
- Serves the butterfly through the same read interface the ROMs expose: raddr in, b out one cycle later.
- Lets one bitstream switch modulus or transform direction without resynthesis.

Parameters:
LOGN, 3, stage address width; 2^LOGN entries; legal range 1..10
LOGQ, 64, twiddle word width
BITREV, 1, 1: the k-th streamed word is written to bitrev_LOGN(k); 0: written to address k

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins or restarts a load
ld_valid  in  1  load beat valid
ld_ready  out  1  loader accepts a beat
ld_data  in  LOGQ  twiddle word
ld_last  in  1  marks the final beat of a load
busy  out  1  load in progress
loaded  out  1  table valid; reads return stored words
err  out  1  sticky framing error
raddr  in  LOGN  butterfly read address
b  out  LOGQ  registered twiddle output

Interface (already decided):
- One clock, clk.
- Reset rst_n is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets: state IDLE, ld_ready=0, busy=0, loaded=0, err=0, b=1, wcnt=0. RAM contents are not cleared.
- Beat accept condition: ld_valid & ld_ready at a rising edge.
- State IDLE:
  - ld_ready=0, busy=0.
  - start -> LOAD; wcnt=0, loaded=0, err=0.
- State LOAD:
  - ld_ready=1, busy=1.
  - Each accepted beat writes ld_data to waddr = BITREV ? bitrev(wcnt) : wcnt, then wcnt increments.
  - Accepted beat with wcnt==2^LOGN-1 -> DONE; loaded=1 from the next cycle.
  - If ld_last=0 on that final beat: err=1, transition to DONE still taken.
  - ld_last=1 on a beat with wcnt<2^LOGN-1: the beat is written, err=1, go to IDLE, loaded stays 0.
  - Stalls (ld_valid=0) hold wcnt indefinitely; no timeout.
- State DONE:
  - ld_ready=0, busy=0, loaded=1.
  - start -> LOAD; loaded=0 immediately and wcnt=0. err is cleared on every start.
- start while in LOAD:
  - Restarts with wcnt=0.
  - If a beat is accepted in the same cycle, that beat is written at address 0 (or bitrev(0)) and wcnt becomes 1, i.e. it counts as the first beat of the new load.
- Read port:
  - Latency 1: b(t+1) = loaded(t) ? mem[raddr(t)] : 1.
  - This matches the ROM default-of-1 convention, so an unloaded table gives identity twiddles.
  - No read-during-write hazard: loaded=0 throughout LOAD, so b=1.
- Widths:
  - wcnt is LOGN+1 bits to avoid wrap.
  - No arithmetic is performed on data; words are stored verbatim.
- Memory: 2^LOGN x LOGQ, 1 write port, 1 synchronous read port, distributed RAM style.
- Reset mid-load: returns to IDLE with loaded=0; the partial table is never exposed.

Decomposition:
- Shared package ntt_pkg holds:
  - loader state encoding (IDLE=0, LOAD=1, DONE=2)
  - function bitrev(value, width)
  - constant TW_DEFAULT = 1
- One sub-module, tw_sdp_ram: simple dual-port distributed RAM (clk, we, waddr, wdata, raddr, rdata registered).
- The FSM, counter and output mux stay in tw_ram_loader_ntt.

Test Plan:
1. Reset, then raddr=0..7 with LOGN=3 -> b=1 on every cycle, loaded=0, ld_ready=0.
2. start, stream 0x10..0x17 back-to-back with ld_last on the 8th beat -> loaded=1 one cycle after the last beat; raddr=4 -> b=0x11, raddr=6 -> b=0x13, raddr=7 -> b=0x17, err=0.
3. Same stream with random ld_valid gaps, plus a second run with BITREV=0 -> identical completion; with BITREV=0, raddr=k returns 0x10+k.
4. ld_last asserted on beat 3 -> err=1, state IDLE, loaded=0, b=1 for all addresses; then a fresh start plus a full load -> err=0, loaded=1.
5. Full load without ld_last -> loaded=1, err=1; then start mid-DONE -> loaded drops the next cycle and b returns 1 during reload.
6. rst_n=0 after 5 beats of a load -> busy=0, loaded=0, b=1; a subsequent full load with 0xA0..0xA7 -> raddr=1 -> b=0xA4.
